ahb_sim_ctrl: RTL and testbench

//  Synthesisable AHB-Lite slave that sits directly downstream of the CPU sub-system bus
//  (biu_pad_h*) at the simulation-control address.
//  - CPU stores to CTRL_ADDR are decoded as console characters or as PASS/FAIL codes.
//  - Characters drain through a small FIFO to a console sink over a valid/ready handshake.
//  - A retire watchdog flags hangs.
//  - Benches and emulation wrappers read sticky status and sim_done instead of snooping the bus.

---
 rtl/sim_ctrl_pkg.sv | 28 ++
 rtl/sim_char_fifo.sv | 57 +++++
 rtl/ahb_sim_ctrl.sv | 142 ++++++++++++++
 tb/tb_ahb_sim_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared constants for the simulation-control AHB slave: PASS/FAIL store
// codes, AHB transfer encodings, status-word bit positions and code decoders.
package sim_ctrl_pkg;

  localparam logic [31:0] PASS_CODE_LO = 32'h0000_0fff;
  localparam logic [31:0] PASS_CODE_HI = 32'hffff_0000;
  localparam logic [31:0] FAIL_CODE_LO = 32'h0000_0eee;
  localparam logic [31:0] FAIL_CODE_HI = 32'heeee_0000;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int STAT_PASS    = 0;
  localparam int STAT_FAIL    = 1;
  localparam int STAT_HANG    = 2;
  localparam int STAT_CNT_LSB = 8;

  function automatic logic is_pass_code(input logic [31:0] data);
    return (data == PASS_CODE_LO) || (data == PASS_CODE_HI);
  endfunction

  function automatic logic is_fail_code(input logic [31:0] data);
    return (data == FAIL_CODE_LO) || (data == FAIL_CODE_HI);
  endfunction

endpackage

// File: rtl/sim_char_fifo.sv
// Console character FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate count register. A push is taken
// while full only when a pop happens in the same cycle.
module sim_char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  // Derive occupancy flags and qualified push/pop strobes.
  always_comb begin
    count     = wptr_r - rptr_r;
    empty     = (wptr_r == rptr_r);
    full      = (count == (AW+1)'(DEPTH));
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    if (empty) begin
      rdata = {WIDTH{1'b0}};
    end else begin
      rdata = mem_r[rptr_r[AW-1:0]];
    end
  end

  // Advance read/write pointers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wptr_r <= wptr_r + (AW+1)'(1);
      if (do_pop_s)  rptr_r <= rptr_r + (AW+1)'(1);
    end
  end

  // Character storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ahb_sim_ctrl.sv
// AHB-Lite simulation-control slave. Stores to CTRL_ADDR either set the
// sticky PASS/FAIL flags or queue a console character; a full queue
// stretches the data phase until the sink drains a slot. A retire
// watchdog flags windows with no forward progress.
module ahb_sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter logic [31:0] CTRL_ADDR  = 32'h6000_fff8,
  parameter int          FIFO_DEPTH = 8,
  parameter int          WDOG_WIN   = 5000
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic        hresp,
  output logic [31:0] hrdata,
  input  logic        retire,
  output logic [7:0]  char_data,
  output logic        char_vld,
  input  logic        char_rdy,
  output logic        sim_pass,
  output logic        sim_fail,
  output logic        sim_hang,
  output logic        sim_done
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CYW = $clog2(WDOG_WIN + 1);

  logic           act_q, wr_q, hit_q;
  logic           pass_r, fail_r, hang_r;
  logic [CYW-1:0] cyc_r;
  logic [15:0]    rcnt_r;

  logic           wr_hit_s, code_pass_s, code_fail_s, char_wr_s;
  logic           pop_s, push_s, stall_s, accept_s, boundary_s, frozen_s;
  logic           fifo_full_s, fifo_empty_s;
  logic [CW-1:0]  fifo_count_s;
  logic [31:0]    status_s;
  logic           unused_htrans0_s;

  // Data-phase decode, stall and bus response. hready is combinational so a
  // pop in the stalled cycle releases the write in that same cycle.
  always_comb begin
    unused_htrans0_s = htrans[0];
    wr_hit_s    = act_q & wr_q & hit_q;
    code_pass_s = wr_hit_s & is_pass_code(hwdata);
    code_fail_s = wr_hit_s & is_fail_code(hwdata);
    char_wr_s   = wr_hit_s & ~code_pass_s & ~code_fail_s;
    char_vld    = ~fifo_empty_s;
    pop_s       = ~fifo_empty_s & char_rdy;
    stall_s     = char_wr_s & fifo_full_s & ~pop_s;
    if (!rst_b) begin
      hready = 1'b1;
    end else begin
      hready = ~stall_s;
    end
    push_s      = char_wr_s & ~stall_s & rst_b;
    accept_s    = hsel & htrans[1] & hready;
    hresp       = 1'b0;
    status_s    = 32'h0000_0000;
    status_s[STAT_CNT_LSB +: 8] = 8'(fifo_count_s);
    status_s[STAT_HANG] = hang_r;
    status_s[STAT_FAIL] = fail_r;
    status_s[STAT_PASS] = pass_r;
    if (act_q && !wr_q) begin
      hrdata = status_s;
    end else begin
      hrdata = 32'h0000_0000;
    end
    sim_pass   = pass_r;
    sim_fail   = fail_r;
    sim_hang   = hang_r;
    sim_done   = (pass_r | fail_r | hang_r) & fifo_empty_s;
    frozen_s   = pass_r | fail_r;
    boundary_s = (cyc_r == CYW'(WDOG_WIN));
  end

  // Address-phase capture; held while the data phase is extended.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      act_q <= 1'b0;
      wr_q  <= 1'b0;
      hit_q <= 1'b0;
    end else if (hready) begin
      act_q <= accept_s;
      wr_q  <= hwrite;
      hit_q <= (haddr == CTRL_ADDR);
    end
  end

  // Sticky PASS/FAIL/HANG flags.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      pass_r <= 1'b0;
      fail_r <= 1'b0;
      hang_r <= 1'b0;
    end else begin
      if (code_pass_s) pass_r <= 1'b1;
      if (code_fail_s) fail_r <= 1'b1;
      if (!frozen_s && boundary_s && rcnt_r == 16'h0000 && !retire) hang_r <= 1'b1;
    end
  end

  // Retire watchdog: window counter 1..WDOG_WIN and saturating retire count;
  // a retire on the boundary cycle belongs to the closing window.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cyc_r  <= CYW'(1);
      rcnt_r <= 16'h0000;
    end else if (!frozen_s) begin
      if (boundary_s) begin
        cyc_r  <= CYW'(1);
        rcnt_r <= 16'h0000;
      end else begin
        cyc_r <= cyc_r + CYW'(1);
        if (retire && rcnt_r != 16'hffff) rcnt_r <= rcnt_r + 16'h0001;
      end
    end
  end

  sim_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (push_s),
    .wdata (hwdata[7:0]),
    .pop   (pop_s),
    .rdata (char_data),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

endmodule

// File: tb/tb_ahb_sim_ctrl.sv
// Directed bench for ahb_sim_ctrl: console characters, FIFO back-pressure,
// PASS/FAIL codes, watchdog boundary and ignored transfers.
module tb_ahb_sim_ctrl;

  localparam logic [31:0] CTRL = 32'h6000_fff8;

  logic        clk = 1'b0;
  logic        rst_b, hsel, hwrite, retire, char_rdy;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata;
  logic        hready, hresp;
  logic [31:0] hrdata;
  logic [7:0]  char_data;
  logic        char_vld, sim_pass, sim_fail, sim_hang, sim_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_sim_ctrl #(.CTRL_ADDR(32'h6000_fff8), .FIFO_DEPTH(8), .WDOG_WIN(5000)) dut (
    .clk(clk), .rst_b(rst_b), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .hready(hready), .hresp(hresp),
    .hrdata(hrdata), .retire(retire), .char_data(char_data),
    .char_vld(char_vld), .char_rdy(char_rdy), .sim_pass(sim_pass),
    .sim_fail(sim_fail), .sim_hang(sim_hang), .sim_done(sim_done)
  );

  task automatic do_reset();
    rst_b = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    haddr = 32'h0; hwdata = 32'h0; retire = 1'b0; char_rdy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b = 1'b1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [1:0] tr);
    hsel = 1'b1; htrans = tr; hwrite = w; haddr = a;
    @(negedge clk);
    checks++;
    if (hready !== 1'b1) begin
      errors++; $display("FAIL addr_hready got %b want 1", hready);
    end
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic data_finish(output int waits);
    bit done_f;
    int n;
    waits = 0; done_f = 1'b0; n = 0;
    while (!done_f && n < 64) begin
      @(negedge clk);
      if (hready === 1'b1) done_f = 1'b1;
      else waits++;
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (!done_f) begin
      errors++; $display("FAIL data_phase_timeout got %0d waits want completion", waits);
    end
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d, output int waits);
    addr_phase(a, 1'b1, 2'b10);
    hwdata = d;
    data_finish(waits);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0, 2'b10);
    @(negedge clk);
    d = hrdata;
    checks++;
    if (hready !== 1'b1) begin
      errors++; $display("FAIL read_hready got %b want 1", hready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_and_chars();
    int w;
    do_reset();
    checks++;
    if ({hready, hresp, hrdata, char_vld, char_data, sim_pass, sim_fail, sim_hang, sim_done}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 8'h00, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b resp=%b rd=%h vld=%b ch=%h p=%b f=%b h=%b d=%b want rdy=1 rest 0",
               hready, hresp, hrdata, char_vld, char_data, sim_pass, sim_fail, sim_hang, sim_done);
    end
    char_rdy = 1'b1;
    ahb_write(CTRL, 32'h0000_0048, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL char_h_waits got %0d want 0", w); end
    checks++;
    if (char_vld !== 1'b1 || char_data !== 8'h48) begin
      errors++; $display("FAIL char_h got vld=%b data=%h want 1/48", char_vld, char_data);
    end
    ahb_write(CTRL, 32'h0000_0069, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL char_i_waits got %0d want 0", w); end
    checks++;
    if (char_vld !== 1'b1 || char_data !== 8'h69) begin
      errors++; $display("FAIL char_i got vld=%b data=%h want 1/69", char_vld, char_data);
    end
    checks++;
    if (sim_done !== 1'b0) begin errors++; $display("FAIL chars_done got %b want 0", sim_done); end
    char_rdy = 1'b0;
  endtask

  task automatic test_backpressure();
    int w;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ahb_write(CTRL, 32'h0000_0030 + 32'(i), w);
      checks++;
      if (w !== 0) begin errors++; $display("FAIL fill_waits[%0d] got %0d want 0", i, w); end
    end
    addr_phase(CTRL, 1'b1, 2'b10);
    hwdata = 32'h0000_0038;
    @(negedge clk);
    checks++;
    if (hready !== 1'b0) begin errors++; $display("FAIL full_stall got %b want 0", hready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (hready !== 1'b0) begin errors++; $display("FAIL full_stall2 got %b want 0", hready); end
    char_rdy = 1'b1;
    #1;
    checks++;
    if (hready !== 1'b1) begin errors++; $display("FAIL pop_release got %b want 1", hready); end
    @(posedge clk); #1;
    char_rdy = 1'b0;
    checks++;
    if (char_data !== 8'h31) begin errors++; $display("FAIL head_after_pop got %h want 31", char_data); end
    ahb_read(CTRL, d);
    checks++;
    if (d !== 32'h0000_0800) begin errors++; $display("FAIL full_count got %h want 00000800", d); end
    // Reset while stalled: hready rises at once and the FIFO empties.
    addr_phase(CTRL, 1'b1, 2'b10);
    hwdata = 32'h0000_0040;
    @(negedge clk);
    checks++;
    if (hready !== 1'b0) begin errors++; $display("FAIL restall got %b want 0", hready); end
    rst_b = 1'b0;
    #1;
    checks++;
    if (hready !== 1'b1) begin errors++; $display("FAIL reset_stall_hready got %b want 1", hready); end
    @(posedge clk); #1;
    rst_b = 1'b1;
    checks++;
    if (char_vld !== 1'b0 || hready !== 1'b1) begin
      errors++; $display("FAIL reset_stall_flush got vld=%b rdy=%b want 0/1", char_vld, hready);
    end
  endtask

  task automatic test_pass_drain();
    int w;
    do_reset();
    ahb_write(CTRL, 32'h0000_0061, w);
    ahb_write(CTRL, 32'h0000_0062, w);
    ahb_write(CTRL, 32'h0000_0063, w);
    ahb_write(CTRL, 32'hffff_0000, w);
    checks++;
    if (w !== 0 || sim_pass !== 1'b1 || sim_done !== 1'b0 || char_data !== 8'h61) begin
      errors++; $display("FAIL pass_code got w=%0d pass=%b done=%b head=%h want 0/1/0/61",
                         w, sim_pass, sim_done, char_data);
    end
    char_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (sim_done !== 1'b0) begin errors++; $display("FAIL done_early got %b want 0", sim_done); end
    @(posedge clk); #1;
    checks++;
    if (sim_done !== 1'b1) begin errors++; $display("FAIL done_after_drain got %b want 1", sim_done); end
    char_rdy = 1'b0;
  endtask

  task automatic test_fail_and_both();
    int w;
    logic [31:0] d;
    do_reset();
    ahb_write(CTRL, 32'h0000_0eee, w);
    checks++;
    if (w !== 0 || sim_fail !== 1'b1 || sim_pass !== 1'b0 || char_vld !== 1'b0) begin
      errors++; $display("FAIL fail_code got w=%0d fail=%b pass=%b vld=%b want 0/1/0/0",
                         w, sim_fail, sim_pass, char_vld);
    end
    ahb_read(CTRL, d);
    checks++;
    if (d !== 32'h0000_0002) begin errors++; $display("FAIL fail_status got %h want 00000002", d); end
    ahb_write(CTRL, 32'h0000_0fff, w);
    ahb_read(CTRL, d);
    checks++;
    if (d !== 32'h0000_0003 || sim_done !== 1'b1) begin
      errors++; $display("FAIL both_status got %h done=%b want 00000003/1", d, sim_done);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    repeat (4999) @(posedge clk);
    #1;
    checks++;
    if (sim_hang !== 1'b0) begin errors++; $display("FAIL hang_early got %b want 0", sim_hang); end
    @(posedge clk); #1;
    checks++;
    if (sim_hang !== 1'b1 || sim_done !== 1'b1) begin
      errors++; $display("FAIL hang_set got hang=%b done=%b want 1/1", sim_hang, sim_done);
    end
    do_reset();
    repeat (4999) @(posedge clk);
    #1;
    retire = 1'b1;
    @(posedge clk); #1;
    retire = 1'b0;
    checks++;
    if (sim_hang !== 1'b0) begin errors++; $display("FAIL hang_boundary_retire got %b want 0", sim_hang); end
    repeat (5000) @(posedge clk);
    #1;
    checks++;
    if (sim_hang !== 1'b1) begin errors++; $display("FAIL hang_next_window got %b want 1", sim_hang); end
  endtask

  task automatic test_ignored();
    int w;
    logic [31:0] d;
    do_reset();
    ahb_write(32'h6000_fff4, 32'h0000_0041, w);
    checks++;
    if (w !== 0 || char_vld !== 1'b0) begin
      errors++; $display("FAIL miss_write got w=%0d vld=%b want 0/0", w, char_vld);
    end
    addr_phase(CTRL, 1'b1, 2'b00);
    hwdata = 32'h0000_0fff;
    data_finish(w);
    checks++;
    if (sim_pass !== 1'b0 || char_vld !== 1'b0) begin
      errors++; $display("FAIL idle_ignored got pass=%b vld=%b want 0/0", sim_pass, char_vld);
    end
    ahb_read(CTRL, d);
    checks++;
    if (d !== 32'h0000_0000 || sim_pass !== 1'b0 || sim_fail !== 1'b0) begin
      errors++; $display("FAIL read_no_effect got %h p=%b f=%b want 0/0/0", d, sim_pass, sim_fail);
    end
  endtask

  initial begin
    test_reset_and_chars();
    test_backpressure();
    test_pass_drain();
    test_fail_and_both();
    test_watchdog();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
